lsu_unit: RTL and testbench

- Parametrised load/store unit that replaces the core's combinational data-memory path (write masking and load masking) with a handshaked, multi-cycle memory interface.
- Sits between the execute stage and data memory.
- Accepts one access at a time, generates byte enables and lane-shifted write data, and sign- or zero-extends load data.
- Detects misaligned addresses, illegal sizes and bus timeouts, and reports them through an error cause.

---
 rtl/lsu_unit.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit: one handshaked access at a time between execute and data memory.
// Generates byte enables and lane-shifted store data, extends load data, and
// reports misaligned, illegal-size and timeout errors.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   lsu_valid/lsu_ready       : core request handshake (ready only in IDLE)
//   lsu_we/lsu_funct/lsu_addr/lsu_wdata : request fields, registered on accept
//   lsu_done/lsu_rdata/lsu_err/lsu_err_cause : one-cycle completion with result
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : memory request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata : memory grant and response
module lsu_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic                    lsu_we,
    input  logic [2:0]              lsu_funct,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    output logic                    lsu_done,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    lsu_err,
    output logic [1:0]              lsu_err_cause,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam int unsigned BW      = DATA_WIDTH / 8;
    localparam int unsigned OW      = $clog2(BW);
    localparam int unsigned SW      = $clog2(DATA_WIDTH);
    localparam int unsigned CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state, next_state;
    logic [2:0]            funct_q;
    logic [OW-1:0]         off_q;
    logic [CW-1:0]         cnt_q;
    logic                  accept, illegal, misaligned, expire;
    logic [OW-1:0]         in_off;
    logic [2:0]            in_off3;
    logic [BW-1:0]         be_base;
    logic                  err_d;
    logic [1:0]            cause_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] shifted, left, load_ext;
    logic [SW-1:0]         sh;

    assign lsu_ready = reset && (state == IDLE);
    assign accept    = lsu_valid && lsu_ready;
    assign in_off    = lsu_addr[OW-1:0];
    assign in_off3   = 3'(in_off);
    // Expiry fires after TIMEOUT cycles in REQ/WAIT; a same-cycle event is checked first.
    assign expire    = (TIMEOUT != 0) && (cnt_q == CW'(TO_LAST));

    // Request decode: size legality, alignment and base byte mask
    always_comb begin
        illegal    = (lsu_funct == 3'b111) || (lsu_we && lsu_funct[2]);
        misaligned = 1'b0;
        be_base    = BW'(1);
        if ((DATA_WIDTH == 32) && ((lsu_funct == 3'b011) || (lsu_funct == 3'b110))) begin
            illegal = 1'b1;
        end
        case (lsu_funct[1:0])
            2'b01: begin
                misaligned = in_off3[0];
                be_base    = BW'(3);
            end
            2'b10: begin
                misaligned = |in_off3[1:0];
                be_base    = BW'(15);
            end
            2'b11: begin
                misaligned = |in_off3;
                be_base    = BW'(255);
            end
            default: be_base = BW'(1);
        endcase
    end

    // Load alignment and extension: shift the lane down, then left/right shift to extend
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (funct_q[1:0])
            2'b00:   sh = SW'(DATA_WIDTH - 8);
            2'b01:   sh = SW'(DATA_WIDTH - 16);
            2'b10:   sh = SW'(DATA_WIDTH - 32);
            default: sh = '0;
        endcase
        left = shifted << sh;
        if (funct_q[2]) begin
            load_ext = left >> sh;
        end else begin
            load_ext = $unsigned($signed(left) >>> sh);
        end
    end

    // Next state and response payload
    always_comb begin
        next_state = state;
        err_d      = 1'b0;
        cause_d    = 2'b00;
        rdata_d    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        next_state = RESP;
                        err_d      = 1'b1;
                        cause_d    = 2'b11;
                    end else if (misaligned) begin
                        next_state = RESP;
                        err_d      = 1'b1;
                        cause_d    = 2'b01;
                    end else begin
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    next_state = WAIT;
                end else if (expire) begin
                    next_state = RESP;
                    err_d      = 1'b1;
                    cause_d    = 2'b10;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    next_state = RESP;
                    rdata_d    = mem_we ? '0 : load_ext;
                end else if (expire) begin
                    next_state = RESP;
                    err_d      = 1'b1;
                    cause_d    = 2'b10;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs, captured request fields and timeout counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            funct_q       <= '0;
            off_q         <= '0;
            cnt_q         <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            lsu_done      <= 1'b0;
            lsu_err       <= 1'b0;
            lsu_err_cause <= 2'b00;
            lsu_rdata     <= '0;
        end else begin
            mem_req       <= (next_state == REQ);
            lsu_done      <= (next_state == RESP);
            lsu_err       <= err_d;
            lsu_err_cause <= cause_d;
            lsu_rdata     <= rdata_d;
            if (accept) begin
                funct_q   <= lsu_funct;
                off_q     <= in_off;
                mem_we    <= lsu_we;
                mem_addr  <= {lsu_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                mem_be    <= be_base << in_off;
                mem_wdata <= lsu_wdata << {in_off, 3'b000};
            end
            if (next_state != state) begin
                cnt_q <= '0;
            end else if (((state == REQ) || (state == WAIT)) && (cnt_q != {CW{1'b1}})) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: a 32-bit and a 64-bit instance share stimulus,
// selected by sel64; expected values are hand-computed constants.
module tb_lsu_unit;
    logic        clk;
    logic        reset;
    logic        sel64;
    logic        valid, we, gnt, rvalid;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [63:0] wdata, rdata;

    logic        valid32, gnt32, rvalid32, valid64, gnt64, rvalid64;
    logic        ready32, done32, err32, req32, mwe32;
    logic [1:0]  cause32;
    logic [31:0] rdata32, maddr32, mwdata32;
    logic [3:0]  be32;
    logic        ready64, done64, err64, req64, mwe64;
    logic [1:0]  cause64;
    logic [63:0] rdata64, mwdata64;
    logic [31:0] maddr64;
    logic [7:0]  be64;

    logic [63:0] o_ready, o_done, o_err, o_cause, o_rdata, o_req, o_we, o_addr, o_be, o_wdata;

    int checks = 0;
    int errors = 0;

    assign valid32  = valid  & ~sel64;
    assign gnt32    = gnt    & ~sel64;
    assign rvalid32 = rvalid & ~sel64;
    assign valid64  = valid  & sel64;
    assign gnt64    = gnt    & sel64;
    assign rvalid64 = rvalid & sel64;

    assign o_ready = sel64 ? 64'(ready64)  : 64'(ready32);
    assign o_done  = sel64 ? 64'(done64)   : 64'(done32);
    assign o_err   = sel64 ? 64'(err64)    : 64'(err32);
    assign o_cause = sel64 ? 64'(cause64)  : 64'(cause32);
    assign o_rdata = sel64 ? rdata64       : 64'(rdata32);
    assign o_req   = sel64 ? 64'(req64)    : 64'(req32);
    assign o_we    = sel64 ? 64'(mwe64)    : 64'(mwe32);
    assign o_addr  = sel64 ? 64'(maddr64)  : 64'(maddr32);
    assign o_be    = sel64 ? 64'(be64)     : 64'(be32);
    assign o_wdata = sel64 ? mwdata64      : 64'(mwdata32);

    lsu_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) u_dut32 (
        .clk(clk), .reset(reset),
        .lsu_valid(valid32), .lsu_ready(ready32), .lsu_we(we), .lsu_funct(funct),
        .lsu_addr(addr), .lsu_wdata(wdata[31:0]),
        .lsu_done(done32), .lsu_rdata(rdata32), .lsu_err(err32), .lsu_err_cause(cause32),
        .mem_req(req32), .mem_we(mwe32), .mem_addr(maddr32), .mem_be(be32),
        .mem_wdata(mwdata32), .mem_gnt(gnt32), .mem_rvalid(rvalid32), .mem_rdata(rdata[31:0])
    );

    lsu_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(16)) u_dut64 (
        .clk(clk), .reset(reset),
        .lsu_valid(valid64), .lsu_ready(ready64), .lsu_we(we), .lsu_funct(funct),
        .lsu_addr(addr), .lsu_wdata(wdata),
        .lsu_done(done64), .lsu_rdata(rdata64), .lsu_err(err64), .lsu_err_cause(cause64),
        .mem_req(req64), .mem_we(mwe64), .mem_addr(maddr64), .mem_be(be64),
        .mem_wdata(mwdata64), .mem_gnt(gnt64), .mem_rvalid(rvalid64), .mem_rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full access: accept at cycle 0, gnt in cycle 1, rvalid in cycle 2, done in cycle 3
    task automatic do_acc(input string tag, input bit w64, input logic we_i, input logic [2:0] f,
                          input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                          input logic [63:0] exp_be, input logic [63:0] exp_addr,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
        sel64 = w64;
        check_eq({tag, "_ready"}, o_ready, 64'd1);
        valid = 1'b1; we = we_i; funct = f; addr = a; wdata = wd;
        @(negedge clk);
        valid = 1'b0;
        check_eq({tag, "_req"}, o_req, 64'd1);
        check_eq({tag, "_addr"}, o_addr, exp_addr);
        check_eq({tag, "_be"}, o_be, exp_be);
        check_eq({tag, "_we"}, o_we, 64'(we_i));
        if (we_i) check_eq({tag, "_wdata"}, o_wdata, exp_wdata);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        check_eq({tag, "_req_drop"}, o_req, 64'd0);
        check_eq({tag, "_early_done"}, o_done, 64'd0);
        rvalid = 1'b1; rdata = rd;
        @(negedge clk);
        rvalid = 1'b0;
        check_eq({tag, "_done"}, o_done, 64'd1);
        check_eq({tag, "_rdata"}, o_rdata, exp_rdata);
        check_eq({tag, "_err"}, o_err, 64'd0);
        check_eq({tag, "_cause"}, o_cause, 64'd0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, o_done, 64'd0);
    endtask

    // Erroneous request: done with the error in cycle 1, no memory request
    task automatic err_acc(input string tag, input bit w64, input logic we_i, input logic [2:0] f,
                           input logic [31:0] a, input logic [63:0] exp_cause);
        sel64 = w64;
        valid = 1'b1; we = we_i; funct = f; addr = a; wdata = '0;
        @(negedge clk);
        valid = 1'b0;
        check_eq({tag, "_done"}, o_done, 64'd1);
        check_eq({tag, "_err"}, o_err, 64'd1);
        check_eq({tag, "_cause"}, o_cause, exp_cause);
        check_eq({tag, "_noreq"}, o_req, 64'd0);
        @(negedge clk);
        check_eq({tag, "_ready"}, o_ready, 64'd1);
        check_eq({tag, "_done_pulse"}, o_done, 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; sel64 = 1'b0; valid = 1'b0; we = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        funct = '0; addr = '0; wdata = '0; rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", o_ready, 64'd0);
        check_eq("rst_req", o_req, 64'd0);
        check_eq("rst_done", o_done, 64'd0);
        check_eq("rst_rdata", o_rdata, 64'd0);
        check_eq("rst_cause", o_cause, 64'd0);
        check_eq("rst_be", o_be, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // 32-bit loads and stores
        do_acc("lb",  1'b0, 1'b0, 3'b000, 32'h103, 64'h0, 64'h80FF_1234, 64'h8, 64'h100, 64'h0, 64'hFFFF_FF80);
        do_acc("lbu", 1'b0, 1'b0, 3'b100, 32'h103, 64'h0, 64'h80FF_1234, 64'h8, 64'h100, 64'h0, 64'h0000_0080);
        do_acc("lh",  1'b0, 1'b0, 3'b001, 32'h102, 64'h0, 64'h80FF_1234, 64'hC, 64'h100, 64'h0, 64'hFFFF_80FF);
        do_acc("lhu", 1'b0, 1'b0, 3'b101, 32'h102, 64'h0, 64'h80FF_1234, 64'hC, 64'h100, 64'h0, 64'h0000_80FF);
        do_acc("lw",  1'b0, 1'b0, 3'b010, 32'h104, 64'h0, 64'h80FF_1234, 64'hF, 64'h104, 64'h0, 64'h80FF_1234);
        do_acc("sh",  1'b0, 1'b1, 3'b001, 32'h202, 64'hAAAA_BEEF, 64'hDEAD_BEEF, 64'hC, 64'h200, 64'hBEEF_0000, 64'h0);
        do_acc("sb",  1'b0, 1'b1, 3'b000, 32'h201, 64'h1234_56CD, 64'hDEAD_BEEF, 64'h2, 64'h200, 64'h3456_CD00, 64'h0);

        // Errors: misaligned, illegal size, illegal-over-misaligned priority
        err_acc("lw_mis",  1'b0, 1'b0, 3'b010, 32'h101, 64'd1);
        err_acc("st_f100", 1'b0, 1'b1, 3'b100, 32'h100, 64'd3);
        err_acc("st_f101", 1'b0, 1'b1, 3'b101, 32'h101, 64'd3);
        err_acc("f111",    1'b0, 1'b0, 3'b111, 32'h100, 64'd3);
        err_acc("ld_32",   1'b0, 1'b0, 3'b011, 32'h100, 64'd3);
        err_acc("lwu_32",  1'b0, 1'b0, 3'b110, 32'h100, 64'd3);

        // Timeout with gnt held low
        sel64 = 1'b0;
        valid = 1'b1; we = 1'b0; funct = 3'b010; addr = 32'h0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            valid = 1'b0;
            if (o_req == 64'd1 && o_done == 64'd0) n++;
        end
        check_eq("to_req_cycles", 64'(n), 64'd16);
        @(negedge clk);
        check_eq("to_done", o_done, 64'd1);
        check_eq("to_err", o_err, 64'd1);
        check_eq("to_cause", o_cause, 64'd2);
        check_eq("to_req_drop", o_req, 64'd0);
        @(negedge clk);
        check_eq("to_ready", o_ready, 64'd1);

        // 64-bit instance
        do_acc("ld64",  1'b1, 1'b0, 3'b011, 32'h18, 64'h0, 64'h1122_3344_5566_7788, 64'hFF, 64'h18, 64'h0, 64'h1122_3344_5566_7788);
        do_acc("lwu64", 1'b1, 1'b0, 3'b110, 32'h1C, 64'h0, 64'h8000_0000_1234_5678, 64'hF0, 64'h18, 64'h0, 64'h0000_0000_8000_0000);
        do_acc("lw64",  1'b1, 1'b0, 3'b010, 32'h1C, 64'h0, 64'h8000_0000_1234_5678, 64'hF0, 64'h18, 64'h0, 64'hFFFF_FFFF_8000_0000);
        do_acc("sw64",  1'b1, 1'b1, 3'b010, 32'h1C, 64'hCAFE_F00D, 64'h0, 64'hF0, 64'h18, 64'hCAFE_F00D_0000_0000, 64'h0);
        err_acc("ld64_mis", 1'b1, 1'b0, 3'b011, 32'h1C, 64'd1);

        // Reset while in REQ drops mem_req the next cycle
        sel64 = 1'b0;
        valid = 1'b1; we = 1'b0; funct = 3'b010; addr = 32'h0;
        @(negedge clk);
        valid = 1'b0;
        check_eq("rreq_req", o_req, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rreq_req_drop", o_req, 64'd0);
        check_eq("rreq_ready_low", o_ready, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rreq_ready", o_ready, 64'd1);

        // Reset while in WAIT, then a late rvalid is ignored
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; reset = 1'b0;
        #1;
        check_eq("rwait_ready_low", o_ready, 64'd0);
        @(negedge clk);
        check_eq("rwait_req", o_req, 64'd0);
        check_eq("rwait_done", o_done, 64'd0);
        reset = 1'b1; rvalid = 1'b1; rdata = 64'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0;
        check_eq("rwait_late_rvalid", o_done, 64'd0);
        @(negedge clk);
        check_eq("rwait_no_done", o_done, 64'd0);
        check_eq("rwait_ready", o_ready, 64'd1);

        // Spurious rvalid in IDLE
        rvalid = 1'b1;
        @(negedge clk);
        check_eq("spur_done0", o_done, 64'd0);
        @(negedge clk);
        rvalid = 1'b0;
        check_eq("spur_done1", o_done, 64'd0);
        check_eq("spur_ready", o_ready, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
